// File: rtl/flit_sink_monitor.sv
// Receive-side packet monitor: frames flits by in_valid runs, counts flits and
// data-bus bit toggles per packet, and offers one report per packet downstream.
module flit_sink_monitor #(
    parameter int N       = 12,
    parameter int PAYLOAD = 20,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_flits,
    output logic [CNT_W-1:0] rpt_toggles,
    output logic             rpt_len_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic             overrun
);

    localparam int PC_W = $clog2(N + 1);
    localparam int SW   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] flit_acc_q, flit_acc_d;
    logic [CNT_W-1:0] tog_acc_q, tog_acc_d;
    logic [N-1:0]     prev_q, prev_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic [CNT_W-1:0] rpt_flits_q, rpt_flits_d;
    logic [CNT_W-1:0] rpt_toggles_q, rpt_toggles_d;
    logic             rpt_len_err_q, rpt_len_err_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             overrun_q, overrun_d;

    logic             drain;
    logic [PC_W-1:0]  flit_toggles;

    function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] x);
        logic [PC_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r = r + PC_W'(x[i]);
        end
        return r;
    endfunction

    // Widened add so the overflow is visible before clamping to the counter max.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SW'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        flit_acc_d    = flit_acc_q;
        tog_acc_d     = tog_acc_q;
        prev_d        = prev_q;
        rpt_valid_d   = rpt_valid_q;
        rpt_flits_d   = rpt_flits_q;
        rpt_toggles_d = rpt_toggles_q;
        rpt_len_err_d = rpt_len_err_q;
        pkt_count_d   = pkt_count_q;
        overrun_d     = overrun_q;

        drain        = rpt_valid_q & rpt_ready;
        flit_toggles = popcount(in_data ^ prev_q);

        if (in_valid) begin
            prev_d = in_data;
        end
        if (drain) begin
            rpt_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = RECV;
                    flit_acc_d = CNT_W'(1);
                    tog_acc_d  = sat_add('0, flit_toggles);
                end
            end
            RECV: begin
                if (in_valid) begin
                    flit_acc_d = sat_add(flit_acc_q, PC_W'(1));
                    tog_acc_d  = sat_add(tog_acc_q, flit_toggles);
                end else begin
                    state_d = IDLE;
                    if (pkt_count_q != CNT_MAX) begin
                        pkt_count_d = pkt_count_q + CNT_W'(1);
                    end
                    // A slot freed by this cycle's handshake may be refilled at once.
                    if (!rpt_valid_q || drain) begin
                        rpt_valid_d   = 1'b1;
                        rpt_flits_d   = flit_acc_q;
                        rpt_toggles_d = tog_acc_q;
                        rpt_len_err_d = (32'(flit_acc_q) != 32'(PAYLOAD));
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            flit_acc_q    <= '0;
            tog_acc_q     <= '0;
            prev_q        <= '0;
            rpt_valid_q   <= 1'b0;
            rpt_flits_q   <= '0;
            rpt_toggles_q <= '0;
            rpt_len_err_q <= 1'b0;
            pkt_count_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flit_acc_q    <= flit_acc_d;
            tog_acc_q     <= tog_acc_d;
            prev_q        <= prev_d;
            rpt_valid_q   <= rpt_valid_d;
            rpt_flits_q   <= rpt_flits_d;
            rpt_toggles_q <= rpt_toggles_d;
            rpt_len_err_q <= rpt_len_err_d;
            pkt_count_q   <= pkt_count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rpt_valid   = rpt_valid_q;
    assign rpt_flits   = rpt_flits_q;
    assign rpt_toggles = rpt_toggles_q;
    assign rpt_len_err = rpt_len_err_q;
    assign pkt_count   = pkt_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Bench for flit_sink_monitor: default-width instance checked through a report
// scoreboard, plus a CNT_W=4 instance for counter saturation.
module tb_flit_sink_monitor;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic [11:0] in_data;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [15:0] rpt_flits;
    logic [15:0] rpt_toggles;
    logic        rpt_len_err;
    logic [15:0] pkt_count;
    logic        overrun;

    logic        s_in_valid;
    logic [11:0] s_in_data;
    logic        s_rpt_valid;
    logic        s_rpt_ready;
    logic [3:0]  s_rpt_flits;
    logic [3:0]  s_rpt_toggles;
    logic        s_rpt_len_err;
    logic [3:0]  s_pkt_count;
    logic        s_overrun;

    typedef struct {
        int flits;
        int toggles;
        bit len_err;
    } rpt_t;

    rpt_t        exp_q[$];
    logic [11:0] prev_m;
    int          checks;
    int          errors;

    flit_sink_monitor #(.N(12), .PAYLOAD(20), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_flits(rpt_flits), .rpt_toggles(rpt_toggles),
        .rpt_len_err(rpt_len_err), .pkt_count(pkt_count),
        .overrun(overrun)
    );

    flit_sink_monitor #(.N(12), .PAYLOAD(20), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_data(s_in_data),
        .rpt_valid(s_rpt_valid), .rpt_ready(s_rpt_ready),
        .rpt_flits(s_rpt_flits), .rpt_toggles(s_rpt_toggles),
        .rpt_len_err(s_rpt_len_err), .pkt_count(s_pkt_count),
        .overrun(s_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reports are compared in the cycle before the handshake edge that consumes them.
    always @(negedge clk) begin
        if (!rst && rpt_valid && rpt_ready) begin
            rpt_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL report_unexpected: got flits=%0d toggles=%0d, required no report",
                         rpt_flits, rpt_toggles);
            end else begin
                e = exp_q.pop_front();
                if (rpt_flits !== 16'(e.flits) || rpt_toggles !== 16'(e.toggles) ||
                    rpt_len_err !== e.len_err) begin
                    errors++;
                    $display("[TB] FAIL report_data: got flits=%0d toggles=%0d len_err=%0b, required flits=%0d toggles=%0d len_err=%0b",
                             rpt_flits, rpt_toggles, rpt_len_err, e.flits, e.toggles, e.len_err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        rpt_ready   = 1'b0;
        s_rpt_ready = 1'b0;
        in_valid    = 1'b0;
        s_in_valid  = 1'b0;
        in_data     = '0;
        s_in_data   = '0;
        tick();
        tick();
        rst    = 1'b0;
        prev_m = '0;
        exp_q.delete();
    endtask

    task automatic build_alt(output logic [11:0] q[$], input int n,
                             input logic [11:0] a, input logic [11:0] b);
        q = {};
        for (int i = 0; i < n; i++) q.push_back((i % 2 == 0) ? a : b);
    endtask

    // Drives one packet plus its one-cycle closing gap; returns in the cycle the report appears.
    task automatic send_pkt(input logic [11:0] d[$], input bit do_push, input bit ready_at_close);
        rpt_t        e;
        logic [11:0] p;
        e.flits   = d.size();
        e.toggles = 0;
        p         = prev_m;
        foreach (d[i]) begin
            e.toggles += $countones(d[i] ^ p);
            p = d[i];
        end
        e.len_err = (d.size() != 20);
        if (do_push) exp_q.push_back(e);
        foreach (d[i]) begin
            in_valid = 1'b1;
            in_data  = d[i];
            tick();
        end
        prev_m   = p;
        in_valid = 1'b0;
        if (ready_at_close) rpt_ready = 1'b1;
        tick();
        if (ready_at_close) rpt_ready = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d reports still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [11:0] q[$];
        do_reset();
        checks++;
        if ({rpt_valid, rpt_flits, rpt_toggles, rpt_len_err, pkt_count, overrun} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%0b flits=%0d toggles=%0d len_err=%0b pkt=%0d ovr=%0b, required all 0",
                     rpt_valid, rpt_flits, rpt_toggles, rpt_len_err, pkt_count, overrun);
        end
        rpt_ready = 1'b1;
        build_alt(q, 20, 12'hFFF, 12'h000);
        send_pkt(q, 1'b1, 1'b0);
        checks++;
        if (rpt_valid !== 1'b1 || rpt_flits !== 16'd20 || rpt_toggles !== 16'd240 || rpt_len_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_pkt_report: got valid=%0b flits=%0d toggles=%0d len_err=%0b, required 1/20/240/0",
                     rpt_valid, rpt_flits, rpt_toggles, rpt_len_err);
        end
        checks++;
        if (pkt_count !== 16'd1 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_pkt_count: got pkt=%0d ovr=%0b, required 1/0", pkt_count, overrun);
        end
        wait_drain("reset");
    endtask

    task automatic test_short();
        logic [11:0] q[$];
        do_reset();
        rpt_ready = 1'b1;
        q = {12'h001, 12'h003, 12'h007};
        send_pkt(q, 1'b1, 1'b0);
        tick();
        q = {12'h007};
        send_pkt(q, 1'b1, 1'b0);
        checks++;
        if (rpt_flits !== 16'd1 || rpt_toggles !== 16'd0 || rpt_len_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_flit: got flits=%0d toggles=%0d len_err=%0b, required 1/0/1",
                     rpt_flits, rpt_toggles, rpt_len_err);
        end
        wait_drain("short");
        checks++;
        if (pkt_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL short_count: got %0d, required 2", pkt_count);
        end
    endtask

    task automatic test_overrun();
        logic [11:0] q[$];
        do_reset();
        build_alt(q, 20, 12'hFFF, 12'h000);
        send_pkt(q, 1'b1, 1'b0);
        build_alt(q, 20, 12'h0F0, 12'h000);
        send_pkt(q, 1'b0, 1'b0);
        checks++;
        if (rpt_valid !== 1'b1 || rpt_flits !== 16'd20 || rpt_toggles !== 16'd240) begin
            errors++;
            $display("[TB] FAIL overrun_held: got valid=%0b flits=%0d toggles=%0d, required 1/20/240",
                     rpt_valid, rpt_flits, rpt_toggles);
        end
        checks++;
        if (overrun !== 1'b1 || pkt_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL overrun_flag: got ovr=%0b pkt=%0d, required 1/2", overrun, pkt_count);
        end
        rpt_ready = 1'b1;
        tick();
        checks++;
        if (rpt_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_drain: got valid=%0b ovr=%0b, required 0/1", rpt_valid, overrun);
        end
        wait_drain("overrun");
    endtask

    task automatic test_back_to_back();
        logic [11:0] q[$];
        do_reset();
        q = {12'h00F, 12'h0F0, 12'hF00};
        send_pkt(q, 1'b1, 1'b0);
        tick();
        q = {12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};
        send_pkt(q, 1'b1, 1'b1);
        checks++;
        if (rpt_valid !== 1'b1 || overrun !== 1'b0 || rpt_flits !== 16'd5) begin
            errors++;
            $display("[TB] FAIL same_cycle_load: got valid=%0b ovr=%0b flits=%0d, required 1/0/5",
                     rpt_valid, overrun, rpt_flits);
        end
        rpt_ready = 1'b1;
        wait_drain("b2b");
        checks++;
        if (rpt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_empty: got valid=%0b, required 0", rpt_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [11:0] q[$];
        do_reset();
        rpt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        prev_m   = '0;
        tick();
        checks++;
        if (rpt_valid !== 1'b0 || pkt_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_discard: got valid=%0b pkt=%0d, required 0/0", rpt_valid, pkt_count);
        end
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(12'($urandom));
        send_pkt(q, 1'b1, 1'b0);
        checks++;
        if (pkt_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d, required 1", pkt_count);
        end
        wait_drain("midreset");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = (i % 2 == 0) ? 12'hFFF : 12'h000;
            tick();
        end
        s_in_valid = 1'b0;
        tick();
        checks++;
        if (s_rpt_valid !== 1'b1 || s_rpt_flits !== 4'd15 || s_rpt_toggles !== 4'd15 || s_rpt_len_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_report: got valid=%0b flits=%0d toggles=%0d len_err=%0b, required 1/15/15/1",
                     s_rpt_valid, s_rpt_flits, s_rpt_toggles, s_rpt_len_err);
        end
        for (int i = 0; i < 20; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = 12'($urandom);
            tick();
            s_in_valid = 1'b0;
            tick();
        end
        tick();
        checks++;
        if (s_pkt_count !== 4'd15 || s_overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_pkt_count: got pkt=%0d ovr=%0b, required 15/1", s_pkt_count, s_overrun);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_short();
        test_overrun();
        test_back_to_back();
        test_reset_mid_packet();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
